// File: rtl/tx_frame_arbiter.sv
// Round-robin transmit arbiter: grants one message source at a time and frames its
// payload as SYNC, ID, LEN, payload, CSUM onto a registered valid/ready byte stream.
module tx_frame_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N_SRC-1:0]     have_msg,
    input  logic [8*N_SRC-1:0]   len,
    input  logic [8*N_SRC-1:0]   data_in,
    output logic [N_SRC-1:0]     rdreq,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy
);
    // state     | meaning
    // S_IDLE    | waiting for a request; round-robin grant from last_grant+1
    // S_SYNC    | loading the sync byte
    // S_ID      | loading the source index
    // S_LEN     | loading the payload length
    // S_PAYLOAD | loading payload bytes, popping the source per byte
    // S_CSUM    | loading the checksum, then back to idle
    // S_DROP    | discarding a zero-length request with a single pop
    localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_ID, S_LEN, S_PAYLOAD, S_CSUM, S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   src_q, src_d;
    logic [SW-1:0]   last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;

    logic            out_free;
    logic            grant_found;
    logic [SW-1:0]   grant_idx;
    logic [SW-1:0]   cand;
    logic [7:0]      grant_len;
    logic [7:0]      cur_byte;
    logic [7:0]      id_byte;

    assign out_free  = !tx_valid_q || tx_ready;
    assign grant_len = len[{grant_idx, 3'b000} +: 8];
    assign cur_byte  = data_in[{src_q, 3'b000} +: 8];
    assign id_byte   = 8'(src_q);
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;

    // First requester at or after last_grant+1, wrapping; last_grant itself is checked last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= int'(N_SRC); i++) begin
            cand = SW'((int'(last_q) + i) % int'(N_SRC));
            if (!grant_found && have_msg[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            last_q     <= SW'(N_SRC - 1);
            cnt_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !tx_ready;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    src_d   = grant_idx;
                    cnt_d   = grant_len;
                    csum_d  = '0;
                    state_d = (grant_len == 8'd0) ? S_DROP : S_SYNC;
                end
            end
            S_DROP: begin
                last_d  = src_q;
                state_d = S_IDLE;
            end
            S_SYNC: begin
                if (out_free) begin
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                if (out_free) begin
                    tx_data_d  = id_byte;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q + id_byte;
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (out_free) begin
                    tx_data_d  = cnt_q;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q + cnt_q;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (out_free) begin
                    tx_data_d  = cur_byte;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q + cur_byte;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (out_free) begin
                    tx_data_d  = csum_q;
                    tx_valid_d = 1'b1;
                    last_d     = src_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pops coincide with the payload load edge, so they share the free condition.
    always_comb begin
        rdreq = '0;
        if ((state_q == S_PAYLOAD && out_free) || state_q == S_DROP) begin
            rdreq[src_q] = 1'b1;
        end
        busy = (state_q != S_IDLE) || tx_valid_q;
    end

endmodule
